// File: rtl/hififo_pkg.sv
// ============================================================================
//  Module   : hififo_pkg
//  Purpose  : Shared constants, header helpers and TX FSM state type for the
//             to-PC Memory Write TLP stage. Optional feature macro:
//             HIFIFO_MWR_3DW_EN (3DW headers for 32-bit addresses).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package hififo_pkg;

  localparam logic [2:0] FMT_MWR_3DW = 3'b010;
  localparam logic [2:0] FMT_MWR_4DW = 3'b011;
  localparam logic [4:0] TYPE_MEM    = 5'b00000;

  localparam int MWR_LEN_DW  = 32;
  localparam int BURST_BEATS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR0 = 2'd1,
    HDR1 = 2'd2,
    DATA = 2'd3
  } tx_state_t;

  // First header DW: fmt/type, TC/attr/TD/EP all zero, fixed length.
  function automatic logic [31:0] mwr_dw0(input logic [2:0] fmt);
    return {fmt, TYPE_MEM, 14'h0000, 10'(MWR_LEN_DW)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/hififo_mwr_buffer.sv
// ============================================================================
//  Module   : hififo_mwr_buffer
//  Purpose  : 64-bit first-word-fall-through burst store. Space is reserved
//             per beat on write and returned 16 entries at a time when the
//             TLP carrying a burst has been fully sent.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hififo_mwr_buffer
  import hififo_pkg::*;
#(
  parameter int BUF_BURSTS = 2
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       wr_en,
  input  logic [63:0]                                wr_data,
  input  logic                                       wr_close,
  input  logic                                       rd_en,
  input  logic                                       release_burst,
  output logic [63:0]                                rd_data,
  output logic [$clog2(BURST_BEATS*BUF_BURSTS):0]    free_next,
  output logic [$clog2(BUF_BURSTS):0]                complete_bursts
);

  localparam int DEPTH = BURST_BEATS * BUF_BURSTS;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(BUF_BURSTS) + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   free_cnt;

  // Reads fall through: the head entry is always visible.
  assign rd_data = mem[rd_ptr];

  // Both the per-beat write and the 16-entry release can land in one cycle.
  assign free_next = free_cnt - (AW+1)'(wr_en)
                   + (release_burst ? (AW+1)'(BURST_BEATS) : '0);

  // Storage array, no reset needed
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers, free space and complete-burst bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      free_cnt        <= (AW+1)'(DEPTH);
      complete_bursts <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      free_cnt        <= free_next;
      complete_bursts <= complete_bursts + CW'(wr_close) - CW'(release_burst);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hififo_tpc_mwr.sv
// ============================================================================
//  Module   : hififo_tpc_mwr
//  Purpose  : Turns 128-byte bursts from the to-PC FIFO engine into PCIe
//             Memory Write TLPs on a 64-bit AXI-stream TX port.
//             Optional macro HIFIFO_MWR_3DW_EN: 3DW header and realigned
//             payload for bursts whose address fits in 32 bits.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hififo_tpc_mwr
  import hififo_pkg::*;
#(
  parameter int BUF_BURSTS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] requester_id,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_data,
  input  logic [63:0] req_addr,
  input  logic        req_last,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [63:0] tx_data,
  output logic [7:0]  tx_keep,
  output logic        tx_last,
  output logic [31:0] tlp_count
);

  localparam int AW = $clog2(BURST_BEATS * BUF_BURSTS);
  localparam int QW = $clog2(BUF_BURSTS);
  localparam int CW = $clog2(BUF_BURSTS) + 1;
  localparam logic [QW:0] AQ_FULL     = (QW+1)'(BUF_BURSTS);
  localparam logic [AW:0] BURST_SPACE = (AW+1)'(BURST_BEATS);

  logic [3:0]    beat_idx, beat_idx_next;
  logic          req_fire, burst_close, aq_push, tlp_done, rd_en;
  logic [63:0]   rd_data;
  logic [AW:0]   free_next;
  logic [CW-1:0] complete_bursts;

  logic [63:2]   aq [BUF_BURSTS];
  logic [QW-1:0] aq_wr, aq_rd;
  logic [QW:0]   aq_cnt, aq_cnt_next;
  logic [63:2]   head_addr;

  tx_state_t     state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic          tx_valid_n, tx_last_n, start;
  logic [7:0]    tx_keep_n;
  logic [63:0]   tx_data_n;

`ifdef HIFIFO_MWR_3DW_EN
  logic          mode3, mode3_n;
  logic [31:0]   hold, hold_n;
  logic [63:2]   hdr_addr;
`endif

  // Framing comes from the beat counter alone; stray req_last and the
  // always-zero low address bits carry no information.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, req_last, req_addr[1:0]};

  assign req_fire      = req_valid && req_ready;
  assign burst_close   = req_fire && (beat_idx == 4'd15);
  assign aq_push       = req_fire && (beat_idx == 4'd0);
  assign tlp_done      = tx_valid && tx_ready && tx_last;
  assign beat_idx_next = req_fire ? beat_idx + 4'd1 : beat_idx;
  assign aq_cnt_next   = aq_cnt + (QW+1)'(aq_push) - (QW+1)'(tlp_done);
  assign head_addr     = aq[aq_rd];

  hififo_mwr_buffer #(
    .BUF_BURSTS (BUF_BURSTS)
  ) u_buffer (
    .clock           (clock),
    .reset           (reset),
    .wr_en           (req_fire),
    .wr_data         (req_data),
    .wr_close        (burst_close),
    .rd_en           (rd_en),
    .release_burst   (tlp_done),
    .rd_data         (rd_data),
    .free_next       (free_next),
    .complete_bursts (complete_bursts)
  );

  // Beat counter, address queue pointers and look-ahead registered ready
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_idx  <= '0;
      aq_wr     <= '0;
      aq_rd     <= '0;
      aq_cnt    <= '0;
      req_ready <= 1'b0;
    end else begin
      beat_idx <= beat_idx_next;
      aq_cnt   <= aq_cnt_next;
      if (aq_push)  aq_wr <= aq_wr + QW'(1);
      if (tlp_done) aq_rd <= aq_rd + QW'(1);
      req_ready <= (beat_idx_next != 4'd0) ||
                   ((free_next >= BURST_SPACE) && (aq_cnt_next < AQ_FULL));
    end
  end

  // Address queue storage, captured on the first beat of each burst
  always_ff @(posedge clock) begin
    if (aq_push) aq[aq_wr] <= req_addr[63:2];
  end

  // Count of fully delivered TLPs
  always_ff @(posedge clock) begin
    if (reset)         tlp_count <= '0;
    else if (tlp_done) tlp_count <= tlp_count + 32'd1;
  end

`ifdef HIFIFO_MWR_3DW_EN
  // At end of a TLP the queue head is about to pop, so the next header
  // must look one entry further.
  assign hdr_addr = (state == DATA) ? aq[aq_rd + QW'(1)] : aq[aq_rd];
`endif

  // Next state and next output beat; the output register only reloads when
  // empty or when the current beat is accepted, which keeps data stable.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    tx_keep_n  = tx_keep;
    tx_last_n  = tx_last;
    rd_en      = 1'b0;
    start      = 1'b0;
`ifdef HIFIFO_MWR_3DW_EN
    mode3_n    = mode3;
    hold_n     = hold;
`endif
    case (state)
      IDLE: begin
        if ((complete_bursts != '0) || burst_close) start = 1'b1;
      end
      HDR0: begin
        if (tx_ready) begin
          state_n = HDR1;
`ifdef HIFIFO_MWR_3DW_EN
          if (mode3) begin
            tx_data_n = {rd_data[31:0], head_addr[31:2], 2'b00};
            hold_n    = rd_data[63:32];
            rd_en     = 1'b1;
          end else begin
            tx_data_n = {head_addr[31:2], 2'b00, head_addr[63:32]};
          end
`else
          tx_data_n = {head_addr[31:2], 2'b00, head_addr[63:32]};
`endif
        end
      end
      HDR1: begin
        if (tx_ready) begin
          state_n = DATA;
          rd_en   = 1'b1;
`ifdef HIFIFO_MWR_3DW_EN
          if (mode3) begin
            tx_data_n = {rd_data[31:0], hold};
            hold_n    = rd_data[63:32];
            cnt_n     = 4'd1;
          end else begin
            tx_data_n = rd_data;
            cnt_n     = 4'd0;
          end
`else
          tx_data_n = rd_data;
          cnt_n     = 4'd0;
`endif
        end
      end
      DATA: begin
        if (tx_ready) begin
          if (tx_last) begin
            if ((complete_bursts > CW'(1)) || burst_close) begin
              start = 1'b1;
            end else begin
              state_n    = IDLE;
              tx_valid_n = 1'b0;
              tx_last_n  = 1'b0;
            end
`ifdef HIFIFO_MWR_3DW_EN
          end else if (mode3) begin
            if (cnt == 4'd15) begin
              tx_data_n = {32'h0000_0000, hold};
              tx_keep_n = 8'h0F;
              tx_last_n = 1'b1;
            end else begin
              tx_data_n = {rd_data[31:0], hold};
              hold_n    = rd_data[63:32];
              rd_en     = 1'b1;
              cnt_n     = cnt + 4'd1;
            end
`endif
          end else begin
            tx_data_n = rd_data;
            rd_en     = 1'b1;
            cnt_n     = cnt + 4'd1;
            tx_last_n = (cnt == 4'd14);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (start) begin
      state_n    = HDR0;
      tx_valid_n = 1'b1;
      tx_last_n  = 1'b0;
      tx_keep_n  = 8'hFF;
`ifdef HIFIFO_MWR_3DW_EN
      mode3_n    = (hdr_addr[63:32] == 32'h0);
      tx_data_n  = {requester_id, 8'h00, 4'hF, 4'hF,
                    mwr_dw0(mode3_n ? FMT_MWR_3DW : FMT_MWR_4DW)};
`else
      tx_data_n  = {requester_id, 8'h00, 4'hF, 4'hF, mwr_dw0(FMT_MWR_4DW)};
`endif
    end
  end

  // FSM state and registered AXI-stream outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      tx_keep  <= 8'h00;
      tx_data  <= '0;
`ifdef HIFIFO_MWR_3DW_EN
      mode3    <= 1'b0;
      hold     <= '0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tx_valid <= tx_valid_n;
      tx_last  <= tx_last_n;
      tx_keep  <= tx_keep_n;
      tx_data  <= tx_data_n;
`ifdef HIFIFO_MWR_3DW_EN
      mode3    <= mode3_n;
      hold     <= hold_n;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hififo_tpc_mwr.sv
// ============================================================================
//  Module   : tb_hififo_tpc_mwr
//  Purpose  : Self-checking bench for hififo_tpc_mwr: table of single-burst
//             cases plus buffer-full, back-to-back and reset-mid-TLP
//             sequences, with a beat-level scoreboard on the TX port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hififo_tpc_mwr;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] requester_id = 16'hBEEF;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_data = '0;
  logic [63:0] req_addr = '0;
  logic        req_last = 1'b0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [63:0] tx_data;
  logic [7:0]  tx_keep;
  logic        tx_last;
  logic [31:0] tlp_count;

  hififo_tpc_mwr #(.BUF_BURSTS(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .requester_id (requester_id),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_addr     (req_addr),
    .req_last     (req_last),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .tx_keep      (tx_keep),
    .tx_last      (tx_last),
    .tlp_count    (tlp_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] seed;
    int          pct;
    bit          bad_last;
    logic [63:0] exp_hdr0;
    logic [63:0] exp_hdr1;
  } case_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          ready_pct = 100;
  int          exp_tlps = 0;
  int          tlp_beat = 0;
  bit          in_tlp = 0;
  bit          prev_stall = 0;
  beat_t       held;
  logic [63:0] cap_hdr0 = '0;
  logic [63:0] cap_hdr1 = '0;
  bit          b2b_arm = 0;
  bit          b2b_watch = 0;
  int          b2b_tlps = 0;
  int          b2b_idle = 0;
  int          first_beat_tlps = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [31:0] seed, input int b);
    return {(seed != 32'h0) ? seed + 32'(b) : 32'h0, 32'(b)};
  endfunction

  // Reference TLP for one burst, built from the DW view of the payload
  task automatic push_tlp(input logic [63:0] addr, input logic [31:0] seed);
    logic [31:0] dw [32];
    logic [63:0] q;
    bit          three;
    beat_t       bt;
    for (int i = 0; i < 16; i++) begin
      q = data_of(seed, i);
      dw[2*i]   = q[31:0];
      dw[2*i+1] = q[63:32];
    end
    three = 1'b0;
`ifdef HIFIFO_MWR_3DW_EN
    three = (addr[63:32] == 32'h0);
`endif
    bt.keep = 8'hFF;
    bt.last = 1'b0;
    bt.data = {requester_id, 8'h00, 8'hFF, three ? 32'h4000_0020 : 32'h6000_0020};
    exp_q.push_back(bt);
    if (three) begin
      bt.data = {dw[0], addr[31:2], 2'b00};
      exp_q.push_back(bt);
      for (int k = 1; k < 16; k++) begin
        bt.data = {dw[2*k], dw[2*k-1]};
        exp_q.push_back(bt);
      end
      bt.data = {32'h0, dw[31]};
      bt.keep = 8'h0F;
      bt.last = 1'b1;
      exp_q.push_back(bt);
    end else begin
      bt.data = {addr[31:2], 2'b00, addr[63:32]};
      exp_q.push_back(bt);
      for (int k = 0; k < 16; k++) begin
        bt.data = data_of(seed, k);
        bt.last = (k == 15);
        exp_q.push_back(bt);
      end
    end
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Caller must be aligned just after a rising edge
  task automatic drive_burst(input logic [63:0] addr, input logic [31:0] seed, input bit bad_last);
    int t;
    push_tlp(addr, seed);
    for (int b = 0; b < 16; b++) begin
      req_valid = 1'b1;
      req_data  = data_of(seed, b);
      req_addr  = (b == 0) ? addr : ~addr;
      req_last  = (b == 15) || (bad_last && b == 7);
      t = 0;
      forever begin
        @(negedge clock);
        if (req_ready) break;
        t++;
        if (t > 3000) begin
          $display("FAIL req_ready_timeout: beat %0d never accepted", b);
          n_errors++;
          $fatal(1, "input side stuck");
        end
      end
      if (b == 0) first_beat_tlps = int'(tlp_count);
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    req_last  = 1'b0;
  endtask

  task automatic wait_tlps(input int target, input int budget);
    int c;
    c = 0;
    while (int'(tlp_count) != target && c < budget) begin
      @(negedge clock);
      c++;
    end
    check64("tlp_count", 64'(tlp_count), 64'(target));
    check64("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // Random TX back-pressure
  initial begin
    forever begin
      @(posedge clock);
      #1;
      tx_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  // TX monitor: scoreboard, hold-while-stalled and no-bubble checks
  initial begin
    beat_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 0;
        in_tlp     = 0;
        tlp_beat   = 0;
      end else begin
        if (prev_stall) begin
          check64("stall_data", tx_data, held.data);
          check64("stall_ctl", {55'h0, tx_valid, tx_last, tx_keep}, {55'h0, 1'b1, held.last, held.keep});
        end
        if (in_tlp) check64("no_bubble", 64'(tx_valid), 64'd1);
        if (b2b_watch && !tx_valid) b2b_idle++;
        if (tx_valid && tx_ready) begin
          if (b2b_arm && !b2b_watch) b2b_watch = 1;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got %h with nothing expected", tx_data);
          end else begin
            e = exp_q.pop_front();
            check64("beat_data", tx_data, e.data);
            check64("beat_ctl", {55'h0, tx_keep, tx_last}, {55'h0, e.keep, e.last});
          end
          if (tlp_beat == 0) cap_hdr0 = tx_data;
          if (tlp_beat == 1) cap_hdr1 = tx_data;
          if (tx_last) begin
            in_tlp   = 0;
            tlp_beat = 0;
            if (b2b_watch) begin
              b2b_tlps++;
              if (b2b_tlps == 4) begin
                b2b_watch = 0;
                b2b_arm   = 0;
              end
            end
          end else begin
            in_tlp = 1;
            tlp_beat++;
          end
        end
        prev_stall = tx_valid && !tx_ready;
        held.data  = tx_data;
        held.keep  = tx_keep;
        held.last  = tx_last;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    case_t tbl [4];
    int    base;
    int    t;

    tbl[0] = '{64'h0000_0001_0000_0080, 32'h0, 100, 1'b0,
               64'hBEEF_00FF_6000_0020, 64'h0000_0080_0000_0001};
`ifdef HIFIFO_MWR_3DW_EN
    tbl[1] = '{64'h0000_0000_1000_0000, 32'hA000_0000, 100, 1'b0,
               64'hBEEF_00FF_4000_0020, 64'h0000_0000_1000_0000};
`else
    tbl[1] = '{64'h0000_0000_1000_0000, 32'hA000_0000, 100, 1'b0,
               64'hBEEF_00FF_6000_0020, 64'h1000_0000_0000_0000};
`endif
    tbl[2] = '{64'hDEAD_BEEF_0000_1000, 32'h1234_0000, 30, 1'b1,
               64'hBEEF_00FF_6000_0020, 64'h0000_1000_DEAD_BEEF};
    tbl[3] = '{64'h0000_0002_8000_0048, 32'h5500_0100, 60, 1'b0,
               64'hBEEF_00FF_6000_0020, 64'h8000_0048_0000_0002};

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check64("rst_tx_valid", 64'(tx_valid), 64'd0);
    check64("rst_tx_last", 64'(tx_last), 64'd0);
    check64("rst_tx_keep", 64'(tx_keep), 64'd0);
    check64("rst_tx_data", tx_data, 64'd0);
    check64("rst_req_ready", 64'(req_ready), 64'd0);
    check64("rst_tlp_count", 64'(tlp_count), 64'd0);
    sync();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check64("req_ready_after_reset", 64'(req_ready), 64'd1);

    // Table of single-burst cases
    for (int i = 0; i < 4; i++) begin
      ready_pct = tbl[i].pct;
      sync();
      drive_burst(tbl[i].addr, tbl[i].seed, tbl[i].bad_last);
      exp_tlps++;
      wait_tlps(exp_tlps, 3000);
      check64("hdr0", cap_hdr0, tbl[i].exp_hdr0);
      check64("hdr1", cap_hdr1, tbl[i].exp_hdr1);
    end

    // Buffer full: two bursts fill it, the third waits for the first TLP
    ready_pct = 0;
    sync();
    sync();
    base = int'(tlp_count);
    drive_burst(64'h0000_0003_0000_0000, 32'h1111_0000, 1'b0);
    drive_burst(64'h0000_0003_0000_0080, 32'h2222_0000, 1'b0);
    repeat (3) @(negedge clock);
    check64("full_req_ready_low", 64'(req_ready), 64'd0);
    check64("full_tx_valid_held", 64'(tx_valid), 64'd1);
    fork
      drive_burst(64'h0000_0003_0000_0100, 32'h3333_0000, 1'b0);
      begin
        repeat (20) @(negedge clock);
        check64("full_still_blocked", 64'(req_ready), 64'd0);
        ready_pct = 100;
      end
    join
    check64("full_third_after_drain", 64'(first_beat_tlps >= base + 1), 64'd1);
    exp_tlps += 3;
    wait_tlps(exp_tlps, 3000);

    // Back-to-back bursts with tx_ready held high
    ready_pct = 100;
    b2b_idle  = 0;
    b2b_tlps  = 0;
    b2b_arm   = 1;
    sync();
    for (int i = 0; i < 4; i++)
      drive_burst(64'h0000_0004_0000_0000 + 64'(i * 128), 32'h4000_0000 + 32'(i << 16), 1'b0);
    exp_tlps += 4;
    wait_tlps(exp_tlps, 3000);
    check64("b2b_idle_cycles", 64'(b2b_idle), 64'd0);
    check64("b2b_tlps_seen", 64'(b2b_tlps), 64'd4);

    // Reset in the middle of a TLP, then a fresh burst
    sync();
    drive_burst(64'h0000_0005_0000_0000, 32'h7700_0000, 1'b0);
    t = 0;
    while (tlp_beat < 7 && t < 200) begin
      @(negedge clock);
      t++;
    end
    check64("mid_tlp_reached", 64'(tlp_beat >= 7), 64'd1);
    sync();
    reset = 1'b1;
    exp_q.delete();
    sync();
    reset = 1'b0;
    @(negedge clock);
    check64("reset_mid_tx_valid", 64'(tx_valid), 64'd0);
    check64("reset_mid_tlp_count", 64'(tlp_count), 64'd0);
    exp_tlps = 1;
    sync();
    drive_burst(64'h0000_0006_0000_0040, 32'h8800_0000, 1'b0);
    wait_tlps(exp_tlps, 3000);
    check64("post_reset_hdr1", cap_hdr1, 64'h0000_0040_0000_0006);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
